mem_arb: RTL and testbench
==========================

# mem_arb

Round-robin arbiter that shares a single port of the `mem` block between up to NREQ requesters, such as the host bus path and the `icp` core. It accepts one request per grant through a valid/ready handshake and drives the memory port with a registered op, address and write data. It hides the memory's one-cycle read latency and returns read data to the granted requester with a one-cycle response pulse. It sits in `top` between the requesters and one `mem` port, replacing ad-hoc direct driving of that port.

## Interface
- NREQ, 2: number of requesters, 2..4.
- ADDR_W, 13: memory word address width.
- DATA_W, 64: data width.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_en  in  1  grant enable; when 0 no new request is accepted, and an in-flight read still completes.
- i_req_valid  in  NREQ  per-requester request valid.
- o_req_ready  out  NREQ  per-requester accept, combinational, at most one bit set.
- i_req_op  in  2*NREQ  per-requester op, 2'h0 NOP, 2'h1 READ, 2'h2 WRITE, 2'h3 reserved and treated as NOP; requester r uses bits [2r+1:2r].
- i_req_addr  in  ADDR_W*NREQ  per-requester address.
- i_req_wdata  in  DATA_W*NREQ  per-requester write data.
- o_rsp_valid  out  NREQ  one-cycle read-data valid, to the requester that issued the read.
- o_rsp_data  out  DATA_W  read data, held until the next response.
- o_mem_op  out  2  memory op, registered.
- o_mem_addr  out  ADDR_W  memory address, registered.
- o_mem_data  out  DATA_W  memory write data, registered.
- i_mem_data  in  DATA_W  memory read data, valid one cycle after READ is presented.
- o_busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, RD_WAIT, RD_DATA; the encoding 2'h3 is illegal and recovers to IDLE.
- Grant selection (IDLE and i_en=1 only):
  - Search starts at last_grant+1 and wraps modulo NREQ.
  - The first requester with i_req_valid=1 wins.
  - o_req_ready of the winner is 1; all other ready bits are 0.
- A transfer occurs on the clock edge where valid & ready are both high. On that edge:
  - last_grant ← winner.
  - o_mem_addr ← winner's address.
- Transfer with WRITE:
  - o_mem_op ← WRITE and o_mem_data ← winner's write data.
  - The FSM stays in IDLE, so back-to-back writes are accepted every cycle.
- Transfer with READ:
  - o_mem_op ← READ and rd_owner ← winner.
  - Next state RD_WAIT.
- Transfer with NOP or reserved op:
  - The request is accepted and last_grant is updated.
  - o_mem_op ← NOP.
  - No response is generated.
- o_mem_op holds for exactly one cycle per accepted READ or WRITE and returns to NOP otherwise. o_mem_addr and o_mem_data hold their last values.
- RD_WAIT → RD_DATA unconditionally. The memory samples the READ during this cycle.
- RD_DATA → IDLE. On this edge:
  - o_rsp_data ← i_mem_data.
  - o_rsp_valid[rd_owner] ← 1 for one cycle.
- A requester may drop or change i_req_valid or its fields before ready without penalty. Fields need not be held after acceptance.
- When i_en falls during RD_WAIT or RD_DATA, the read completes normally; no grant follows until i_en=1.

## Timing
- Reset value of every output:
  - o_mem_op = NOP; o_mem_addr = 0; o_mem_data = 0.
  - o_rsp_valid = 0; o_rsp_data = 0.
  - o_busy = 0; o_req_ready = 0 while reset is asserted.
- Internal state after reset: state = IDLE; last_grant = NREQ-1, so requester 0 has first priority.
- Write: accepted at edge k; o_mem_op=WRITE during cycle k..k+1; next accept possible at edge k+1.
- Read sequence, accepted at edge k:
  - o_mem_op=READ during cycle k..k+1; memory data valid in cycle k+1..k+2.
  - o_rsp_valid high during cycle k+2..k+3.
  - o_req_ready can go high again in cycle k+2..k+3; earliest next accept is edge k+3.
- Reset mid-read: the FSM returns to IDLE immediately, the pending response is dropped, and no o_rsp_valid pulse is produced.
- Simultaneous valid on all requesters gives strict rotation: 0,1,…,NREQ-1,0.

## Test plan
- Reset then idle: all outputs take their reset values; o_req_ready=0 with no valid.
- Single write: requester 0 issues WRITE to addr 0x005 with data 0xDEAD_BEEF. Required: o_mem_op=2'h2, o_mem_addr=0x005 and o_mem_data=0xDEAD_BEEF for exactly one cycle. A READ from 0x005 then returns o_rsp_valid=2'b01 with o_rsp_data=0xDEAD_BEEF, 3 cycles after its accept.
- Contention: both requesters hold valid WRITE continuously for 6 cycles. Required grant order 0,1,0,1,0,1; one grant per cycle; never two ready bits high together.
- Read ownership: requester 1 READ 0x010 and requester 0 READ 0x011 requested together. Required: each o_rsp_valid pulse goes only to its own requester with the correct data, and no grant occurs while o_busy=1.
- i_en gating: i_en drops during RD_WAIT. Required: the response is still delivered, and no ready bit rises until i_en=1.
- Async reset during RD_DATA. Required: all outputs go to reset values immediately, with no o_rsp_valid pulse; after release, requester 0 wins first.

Source files
------------

// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter sharing one memory port between NREQ requesters.
// Accepts one request per grant (valid/ready), drives a registered memory op,
// and returns read data to the issuing requester as a one-cycle pulse.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   S_IDLE    | granting; WRITE/NOP transfers stay here, READ leaves
//   S_RD_WAIT | READ on the memory port, memory samples it this cycle
//   S_RD_DATA | memory data valid; captured into the response on exit
//   2'h3      | illegal, recovers to S_IDLE
module mem_arb #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic [NREQ-1:0]          i_req_valid,
    output logic [NREQ-1:0]          o_req_ready,
    input  logic [2*NREQ-1:0]        i_req_op,
    input  logic [ADDR_W*NREQ-1:0]   i_req_addr,
    input  logic [DATA_W*NREQ-1:0]   i_req_wdata,
    output logic [NREQ-1:0]          o_rsp_valid,
    output logic [DATA_W-1:0]        o_rsp_data,
    output logic [1:0]               o_mem_op,
    output logic [ADDR_W-1:0]        o_mem_addr,
    output logic [DATA_W-1:0]        o_mem_data,
    input  logic [DATA_W-1:0]        i_mem_data,
    output logic                     o_busy
);

    localparam int LG_W = $clog2(NREQ);

    localparam logic [1:0] OP_NOP   = 2'h0;
    localparam logic [1:0] OP_READ  = 2'h1;
    localparam logic [1:0] OP_WRITE = 2'h2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'h0,
        S_RD_WAIT = 2'h1,
        S_RD_DATA = 2'h2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [LG_W-1:0]     r_last_grant;
    logic [LG_W-1:0]     r_rd_owner;
    logic [1:0]          r_mem_op;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_data;
    logic [NREQ-1:0]     r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;

    logic                w_found;
    logic [LG_W-1:0]     w_winner;
    logic [1:0]          w_op;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_xfer;
    int                  w_idx;

    // Round-robin search starting one past the last grant; first valid wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_op     = OP_NOP;
        w_addr   = '0;
        w_wdata  = '0;
        w_idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (int'(r_last_grant) + k) % NREQ;
            if (!w_found && i_req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = LG_W'(w_idx);
                w_op     = i_req_op[2*w_idx +: 2];
                w_addr   = i_req_addr[ADDR_W*w_idx +: ADDR_W];
                w_wdata  = i_req_wdata[DATA_W*w_idx +: DATA_W];
            end
        end
    end

    assign w_xfer = (r_state == S_IDLE) && i_en && w_found;

    // One-hot ready to the winner; held low while reset is asserted.
    always_comb begin
        o_req_ready = '0;
        if (i_rst_n && w_xfer) begin
            o_req_ready[w_winner] = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE:    w_next_state = (w_xfer && w_op == OP_READ) ? S_RD_WAIT : S_IDLE;
            S_RD_WAIT: w_next_state = S_RD_DATA;
            S_RD_DATA: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Memory port registers and grant bookkeeping; op pulses for one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant <= LG_W'(NREQ - 1);
            r_rd_owner   <= '0;
            r_mem_op     <= OP_NOP;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
        end else begin
            r_mem_op <= OP_NOP;
            if (w_xfer) begin
                r_last_grant <= w_winner;
                r_mem_addr   <= w_addr;
                if (w_op == OP_WRITE) begin
                    r_mem_op   <= OP_WRITE;
                    r_mem_data <= w_wdata;
                end else if (w_op == OP_READ) begin
                    r_mem_op   <= OP_READ;
                    r_rd_owner <= w_winner;
                end
            end
        end
    end

    // Read response: capture memory data and pulse the owner's valid bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (r_state == S_RD_DATA) begin
                r_rsp_valid[r_rd_owner] <= 1'b1;
                r_rsp_data              <= i_mem_data;
            end
        end
    end

    assign o_mem_op    = r_mem_op;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_data  = r_mem_data;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arb.sv
// Directed testbench for mem_arb with NREQ=2 and a one-cycle-latency memory model.
module tb_mem_arb;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 64;

    localparam logic [1:0] NOP = 2'h0;
    localparam logic [1:0] RD  = 2'h1;
    localparam logic [1:0] WR  = 2'h2;
    localparam logic [1:0] RSV = 2'h3;
    localparam logic [63:0] PAT = 64'hA5A5_0000_0000_0000;

    logic                   i_clk;
    logic                   i_rst_n;
    logic                   i_en;
    logic [NREQ-1:0]        i_req_valid;
    logic [NREQ-1:0]        o_req_ready;
    logic [2*NREQ-1:0]      i_req_op;
    logic [ADDR_W*NREQ-1:0] i_req_addr;
    logic [DATA_W*NREQ-1:0] i_req_wdata;
    logic [NREQ-1:0]        o_rsp_valid;
    logic [DATA_W-1:0]      o_rsp_data;
    logic [1:0]             o_mem_op;
    logic [ADDR_W-1:0]      o_mem_addr;
    logic [DATA_W-1:0]      o_mem_data;
    logic [DATA_W-1:0]      i_mem_data;
    logic                   o_busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] mem [int];

    mem_arb #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (i_en),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_op    (i_req_op),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_data  (o_rsp_data),
        .o_mem_op    (o_mem_op),
        .o_mem_addr  (o_mem_addr),
        .o_mem_data  (o_mem_data),
        .i_mem_data  (i_mem_data),
        .o_busy      (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Memory model: unwritten words read back as PAT | addr, one-cycle latency.
    always @(posedge i_clk) begin
        if (o_mem_op == RD) begin
            i_mem_data <= mem.exists(int'(o_mem_addr)) ? mem[int'(o_mem_addr)]
                                                       : (PAT | 64'(o_mem_addr));
        end
        if (o_mem_op == WR) begin
            mem[int'(o_mem_addr)] = o_mem_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic [1:0] op,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        i_req_valid[r]               = v;
        i_req_op[2*r +: 2]           = op;
        i_req_addr[ADDR_W*r +: ADDR_W] = a;
        i_req_wdata[DATA_W*r +: DATA_W] = d;
    endtask

    task automatic clr_req();
        i_req_valid = '0;
        i_req_op    = '0;
    endtask

    initial begin
        int exp_r;
        i_rst_n     = 1'b0;
        i_en        = 1'b1;
        i_req_valid = '0;
        i_req_op    = '0;
        i_req_addr  = '0;
        i_req_wdata = '0;

        // Reset values
        #2;
        chk("rst_mem_op", 64'(o_mem_op), 64'(NOP));
        chk("rst_mem_addr", 64'(o_mem_addr), 64'h0);
        chk("rst_mem_data", o_mem_data, 64'h0);
        chk("rst_rsp_valid", 64'(o_rsp_valid), 64'h0);
        chk("rst_rsp_data", o_rsp_data, 64'h0);
        chk("rst_busy", 64'(o_busy), 64'h0);
        chk("rst_ready", 64'(o_req_ready), 64'h0);
        i_req_valid = 2'b11;
        #1;
        chk("rst_ready_with_valid", 64'(o_req_ready), 64'h0);
        i_req_valid = '0;
        #10;
        i_rst_n = 1'b1;
        tick();
        #1;
        chk("idle_ready", 64'(o_req_ready), 64'h0);
        chk("idle_busy", 64'(o_busy), 64'h0);

        // Single write from requester 0
        set_req(0, 1'b1, WR, 13'h005, 64'hDEAD_BEEF);
        #1;
        chk("wr_ready", 64'(o_req_ready), 64'h1);
        tick();
        clr_req();
        #1;
        chk("wr_mem_op", 64'(o_mem_op), 64'(WR));
        chk("wr_mem_addr", 64'(o_mem_addr), 64'h005);
        chk("wr_mem_data", o_mem_data, 64'hDEAD_BEEF);
        chk("wr_busy", 64'(o_busy), 64'h0);
        tick();
        #1;
        chk("wr_op_one_cycle", 64'(o_mem_op), 64'(NOP));
        chk("wr_addr_hold", 64'(o_mem_addr), 64'h005);

        // Read back from requester 0
        set_req(0, 1'b1, RD, 13'h005, 64'h0);
        #1;
        chk("rd_ready", 64'(o_req_ready), 64'h1);
        tick();
        clr_req();
        #1;
        chk("rd_mem_op", 64'(o_mem_op), 64'(RD));
        chk("rd_busy_wait", 64'(o_busy), 64'h1);
        tick();
        #1;
        chk("rd_busy_data", 64'(o_busy), 64'h1);
        chk("rd_no_rsp_yet", 64'(o_rsp_valid), 64'h0);
        chk("rd_op_dropped", 64'(o_mem_op), 64'(NOP));
        tick();
        #1;
        chk("rd_rsp_valid", 64'(o_rsp_valid), 64'h1);
        chk("rd_rsp_data", o_rsp_data, 64'hDEAD_BEEF);
        chk("rd_busy_done", 64'(o_busy), 64'h0);
        tick();
        #1;
        chk("rd_rsp_pulse", 64'(o_rsp_valid), 64'h0);
        chk("rd_rsp_hold", o_rsp_data, 64'hDEAD_BEEF);

        // Reserved op from requester 1: accepted as NOP, moves last_grant to 1
        set_req(1, 1'b1, RSV, 13'h0AA, 64'h0);
        #1;
        chk("nop_ready", 64'(o_req_ready), 64'h2);
        tick();
        clr_req();
        #1;
        chk("nop_mem_op", 64'(o_mem_op), 64'(NOP));
        chk("nop_mem_addr", 64'(o_mem_addr), 64'h0AA);
        chk("nop_busy", 64'(o_busy), 64'h0);
        tick();
        #1;
        chk("nop_no_rsp", 64'(o_rsp_valid), 64'h0);

        // Contention: both write continuously, strict alternation starting at 0
        set_req(0, 1'b1, WR, 13'h100, 64'h1000);
        set_req(1, 1'b1, WR, 13'h101, 64'h1001);
        for (int i = 0; i < 6; i++) begin
            exp_r = i % 2;
            #1;
            chk($sformatf("cont_ready_%0d", i), 64'(o_req_ready), 64'(1) << exp_r);
            tick();
            #1;
            chk($sformatf("cont_op_%0d", i), 64'(o_mem_op), 64'(WR));
            chk($sformatf("cont_addr_%0d", i), 64'(o_mem_addr), 64'h100 + 64'(exp_r));
            chk($sformatf("cont_data_%0d", i), o_mem_data, 64'h1000 + 64'(exp_r));
        end
        clr_req();
        tick();
        #1;
        chk("cont_end_op", 64'(o_mem_op), 64'(NOP));

        // Read ownership: requester 0 wins first (last_grant=1), then requester 1
        set_req(1, 1'b1, RD, 13'h010, 64'h0);
        set_req(0, 1'b1, RD, 13'h011, 64'h0);
        #1;
        chk("own_ready0", 64'(o_req_ready), 64'h1);
        tick();
        set_req(0, 1'b0, NOP, 13'h0, 64'h0);
        #1;
        chk("own_busy_ready_a", 64'(o_req_ready), 64'h0);
        chk("own_op0", 64'(o_mem_op), 64'(RD));
        chk("own_addr0", 64'(o_mem_addr), 64'h011);
        tick();
        #1;
        chk("own_busy_ready_b", 64'(o_req_ready), 64'h0);
        chk("own_busy", 64'(o_busy), 64'h1);
        tick();
        #1;
        chk("own_rsp0_valid", 64'(o_rsp_valid), 64'h1);
        chk("own_rsp0_data", o_rsp_data, PAT | 64'h011);
        chk("own_ready1", 64'(o_req_ready), 64'h2);
        tick();
        clr_req();
        #1;
        chk("own_rsp0_pulse", 64'(o_rsp_valid), 64'h0);
        chk("own_op1", 64'(o_mem_op), 64'(RD));
        chk("own_addr1", 64'(o_mem_addr), 64'h010);
        tick();
        tick();
        #1;
        chk("own_rsp1_valid", 64'(o_rsp_valid), 64'h2);
        chk("own_rsp1_data", o_rsp_data, PAT | 64'h010);

        // Enable gating: i_en drops during RD_WAIT
        set_req(0, 1'b1, RD, 13'h020, 64'h0);
        #1;
        chk("en_ready", 64'(o_req_ready), 64'h1);
        tick();
        clr_req();
        i_en = 1'b0;
        set_req(1, 1'b1, WR, 13'h030, 64'h3030);
        #1;
        chk("en_ready_wait", 64'(o_req_ready), 64'h0);
        tick();
        #1;
        chk("en_ready_data", 64'(o_req_ready), 64'h0);
        tick();
        #1;
        chk("en_rsp_valid", 64'(o_rsp_valid), 64'h1);
        chk("en_rsp_data", o_rsp_data, PAT | 64'h020);
        chk("en_ready_idle", 64'(o_req_ready), 64'h0);
        tick();
        #1;
        chk("en_ready_still_low", 64'(o_req_ready), 64'h0);
        chk("en_no_op", 64'(o_mem_op), 64'(NOP));
        i_en = 1'b1;
        #1;
        chk("en_ready_back", 64'(o_req_ready), 64'h2);
        tick();
        clr_req();
        #1;
        chk("en_wr_op", 64'(o_mem_op), 64'(WR));
        chk("en_wr_addr", 64'(o_mem_addr), 64'h030);

        // Async reset during RD_DATA
        set_req(1, 1'b1, RD, 13'h040, 64'h0);
        #1;
        chk("ar_ready", 64'(o_req_ready), 64'h2);
        tick();
        clr_req();
        #1;
        chk("ar_op", 64'(o_mem_op), 64'(RD));
        tick();
        #1;
        chk("ar_busy_before", 64'(o_busy), 64'h1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("ar_busy", 64'(o_busy), 64'h0);
        chk("ar_rsp_valid", 64'(o_rsp_valid), 64'h0);
        chk("ar_mem_op", 64'(o_mem_op), 64'(NOP));
        chk("ar_mem_addr", 64'(o_mem_addr), 64'h0);
        chk("ar_mem_data", o_mem_data, 64'h0);
        chk("ar_rsp_data", o_rsp_data, 64'h0);
        chk("ar_ready", 64'(o_req_ready), 64'h0);
        tick();
        #1;
        chk("ar_no_pulse", 64'(o_rsp_valid), 64'h0);
        #2;
        i_rst_n = 1'b1;
        set_req(0, 1'b1, WR, 13'h100, 64'h1000);
        set_req(1, 1'b1, WR, 13'h101, 64'h1001);
        #1;
        chk("ar_first_winner", 64'(o_req_ready), 64'h1);
        tick();
        clr_req();
        #1;
        chk("ar_first_addr", 64'(o_mem_addr), 64'h100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
